// File: rtl/gcd_pkg.sv
// Shared definitions for the binary GCD engine.
// Holds the default operand width and the engine's FSM state encoding.
package gcd_pkg;

  // Default operand/result width used when the engine is not overridden.
  localparam int GCD_DEFAULT_WIDTH = 8;

  // Controller states: wait for work, strip common factors of two,
  // reduce the odd parts, publish the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REDUCE = 2'd2,
    FINISH = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_engine.sv
// Binary (Stein) GCD engine, one elementary step per clock.
//
// Ports:
//   clk   - sole clock, rising-edge
//   rst   - asynchronous active-low reset
//   start - request a computation on P,Q (taken only while busy is low)
//   P, Q  - unsigned operands, sampled on the accept edge only
//   R     - registered gcd(P,Q), held until the next result
//   done  - one-cycle pulse when R carries a new result
//   busy  - high from the cycle after accept through the done cycle
//   err   - registered flag: last accepted operands were both zero
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_DEFAULT_WIDTH,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             done,
  output logic             busy,
  output logic             err
);

  gcd_state_e       state_r, state_nxt_s;
  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;
  logic [KW-1:0]    k_r, k_nxt_s;
  logic [WIDTH-1:0] r_r, r_nxt_s;
  logic             done_r, done_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             err_r, err_nxt_s;

  logic             a_zero_s;
  logic             b_zero_s;
  logic             a_ge_b_s;
  logic [WIDTH-1:0] a_half_s;
  logic [WIDTH-1:0] b_half_s;
  logic [WIDTH-1:0] a_minus_b_s;
  logic [WIDTH-1:0] b_minus_a_s;

  // Inline compare/subtract/halve datapath shared by SHIFT and REDUCE.
  always_comb begin
    a_zero_s    = (a_r == {WIDTH{1'b0}});
    b_zero_s    = (b_r == {WIDTH{1'b0}});
    a_ge_b_s    = (a_r >= b_r);
    a_half_s    = {1'b0, a_r[WIDTH-1:1]};
    b_half_s    = {1'b0, b_r[WIDTH-1:1]};
    // Only the subtraction selected by a_ge_b_s is ever used, so neither wraps.
    a_minus_b_s = a_r - b_r;
    b_minus_a_s = b_r - a_r;
  end

  // Next-state and next-register logic; everything holds unless a state acts.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    k_nxt_s     = k_r;
    r_nxt_s     = r_r;
    done_nxt_s  = 1'b0;
    busy_nxt_s  = busy_r;
    err_nxt_s   = err_r;

    case (state_r)
      IDLE: begin
        if (done_r) begin
          // The done cycle still counts as busy; release afterwards so a
          // start seen alongside done is not taken on this edge.
          busy_nxt_s = 1'b0;
        end else if (start && !busy_r) begin
          a_nxt_s     = P;
          b_nxt_s     = Q;
          k_nxt_s     = {KW{1'b0}};
          err_nxt_s   = 1'b0;
          busy_nxt_s  = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SHIFT: begin
        if (a_zero_s || b_zero_s) begin
          state_nxt_s = FINISH;
        end else if (!a_r[0] && !b_r[0]) begin
          // Common factor of two: remember it in k and restore it at the end.
          a_nxt_s = a_half_s;
          b_nxt_s = b_half_s;
          k_nxt_s = k_r + {{(KW-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = REDUCE;
        end
      end

      REDUCE: begin
        if (a_zero_s || b_zero_s) begin
          state_nxt_s = FINISH;
        end else if (!a_r[0]) begin
          a_nxt_s = a_half_s;
        end else if (!b_r[0]) begin
          b_nxt_s = b_half_s;
        end else if (a_ge_b_s) begin
          a_nxt_s = a_minus_b_s;
        end else begin
          b_nxt_s = b_minus_a_s;
        end
      end

      FINISH: begin
        // One of a/b is zero here, so a|b is the surviving odd part.
        r_nxt_s     = (a_r | b_r) << k_r;
        done_nxt_s  = 1'b1;
        err_nxt_s   = a_zero_s && b_zero_s;
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      k_r     <= {KW{1'b0}};
      r_r     <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      k_r     <= k_nxt_s;
      r_r     <= r_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign R    = r_r;
  assign done = done_r;
  assign busy = busy_r;
  assign err  = err_r;

endmodule
